// File: rtl/eater_pkg.sv
// Shared constants and state types for the program loader and its UART receiver.
package eater_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned PROG_LEN  = 16;
    localparam int unsigned ADDR_W    = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StRelease,
        StError
    } loader_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Emits a one-cycle byte_valid_o or frame_err_o in the cycle after the stop-bit sample.
module uart_rx
    import eater_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned      CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]      sync_q;
    logic            prev_q;
    rx_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            valid_q;
    logic            ferr_q;

    logic rx_s;
    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                RxIdle: begin
                    if (prev_q && !rx_s) begin
                        state_q <= RxStart;
                        cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    if (cnt_q == HalfCnt) begin
                        cnt_q <= '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        if (rx_s) begin
                            state_q <= RxIdle;
                        end else begin
                            state_q <= RxData;
                            bit_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RxData: begin
                    if (cnt_q == LastCnt) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= RxStop;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RxStop: begin
                    if (cnt_q == LastCnt) begin
                        cnt_q   <= '0;
                        state_q <= RxIdle;
                        valid_q <= rx_s;
                        ferr_q  <= !rx_s;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= RxIdle;
            endcase
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/eater_loader.sv
// Serial program loader: receives A5 + 16 bytes over UART into CPU RAM while holding the CPU
// in reset. Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module eater_loader
    import eater_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 104,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              uart_rx_i,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_data_o,
    output logic              cpu_reset_o,
    output logic              load_done_o,
    output logic              err_o
);

    localparam int unsigned        TmrW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmrW-1:0]   TmrLast  = TmrW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PROG_LEN - 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rx_i        (uart_rx_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_ferr)
    );

    loader_state_e     state_q;
    logic [ADDR_W-1:0] addr_cnt_q;
    logic [TmrW-1:0]   timer_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_data_q;
    logic              cpu_reset_q;
    logic              load_done_q;
    logic              err_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    logic is_sync;
    assign is_sync = rx_valid && (rx_byte == SYNC_BYTE);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            addr_cnt_q  <= '0;
            timer_q     <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            ram_we_q    <= 1'b0;
            load_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cpu_reset_q <= 1'b0;
                    if (is_sync) begin
                        state_q     <= StLoad;
                        cpu_reset_q <= 1'b1;
                        addr_cnt_q  <= '0;
                        timer_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q       <= '0;
`endif
                    end
                end
                StLoad: begin
                    // Leave only once the final write strobe has been presented.
                    if (ram_we_q && ram_addr_q == LastAddr) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q     <= StCheck;
`else
                        state_q     <= StRelease;
                        load_done_q <= 1'b1;
`endif
                        timer_q <= timer_q + TmrW'(1);
                    end else if (rx_ferr) begin
                        state_q <= StError;
                        err_q   <= 1'b1;
                    end else if (rx_valid) begin
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= addr_cnt_q;
                        ram_data_q <= rx_byte;
                        timer_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= sum_q + rx_byte;
`endif
                        if (addr_cnt_q != LastAddr) begin
                            addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
                        end
                    end else if (timer_q == TmrLast) begin
                        state_q <= StError;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TmrW'(1);
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StCheck: begin
                    if (rx_ferr) begin
                        state_q <= StError;
                        err_q   <= 1'b1;
                    end else if (rx_valid) begin
                        timer_q <= '0;
                        if (rx_byte == sum_q) begin
                            state_q     <= StRelease;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q <= StError;
                            err_q   <= 1'b1;
                        end
                    end else if (timer_q == TmrLast) begin
                        state_q <= StError;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TmrW'(1);
                    end
                end
`endif
                StRelease: begin
                    state_q     <= StIdle;
                    cpu_reset_q <= 1'b0;
                end
                StError: begin
                    if (is_sync) begin
                        state_q    <= StLoad;
                        err_q      <= 1'b0;
                        addr_cnt_q <= '0;
                        timer_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= '0;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_data_o  = ram_data_q;
    assign cpu_reset_o = cpu_reset_q;
    assign load_done_o = load_done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_eater_loader.sv
// Self-checking bench for eater_loader: table-driven frames, corner sequences, random frames.
module tb_eater_loader;

    localparam int unsigned CLKS = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       rx = 1'b1;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       cpu_reset;
    logic       load_done;
    logic       err;

    eater_loader #(
        .CLKS_PER_BIT  (CLKS),
        .TIMEOUT_CYCLES(400)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .uart_rx_i  (rx),
        .ram_we_o   (ram_we),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_data),
        .cpu_reset_o(cpu_reset),
        .load_done_o(load_done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        int n_send;
        int bad_pos;
        bit cks_good;
        int exp_n;
        bit exp_done;
        bit exp_err;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    wr_t  wr_q[$];
    int   done_cnt = 0;
    int   we_in_rst = 0;
    bit   prev_done = 1'b0;
    logic [7:0] frame_d[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Observe outputs 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (ram_we) begin
            wr_q.push_back('{a: ram_addr, d: ram_data});
            if (reset_i) we_in_rst++;
            check("write context", {30'd0, cpu_reset, err}, 32'd2);
        end
        if (prev_done) check("cpu_reset falls after done", {31'd0, cpu_reset}, 32'd0);
        prev_done = load_done;
        if (load_done) begin
            done_cnt++;
            check("cpu_reset held in release", {31'd0, cpu_reset}, 32'd1);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx = ~bad_stop;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (bad_stop ? CLKS : 2) @(negedge clk);
    endtask

    function automatic logic [7:0] frame_sum();
        logic [7:0] s = 8'd0;
        for (int i = 0; i < 16; i++) s = s + frame_d[i];
        return s;
    endfunction

    task automatic clear_obs();
        wr_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (4) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        clear_obs();
    endtask

    task automatic send_frame(input int n_send, input int bad_pos, input logic [7:0] cks);
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < n_send; i++) send_byte(frame_d[i], 1'b0);
        if (bad_pos >= 0) send_byte(frame_d[bad_pos], 1'b1);
        if (CKS && n_send == 16 && bad_pos < 0) send_byte(cks, 1'b0);
    endtask

    task automatic expect_result(input string tag, input int exp_n, input bit exp_done,
                                 input bit exp_err);
        repeat (exp_done ? 20 : 450) @(negedge clk);
        check({tag, " write count"}, wr_q.size(), exp_n);
        for (int i = 0; i < wr_q.size() && i < exp_n; i++) begin
            check({tag, " addr"}, {28'd0, wr_q[i].a}, i);
            check({tag, " data"}, {24'd0, wr_q[i].d}, {24'd0, frame_d[i]});
        end
        check({tag, " done count"}, done_cnt, {31'd0, exp_done});
        check({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, " cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !exp_done});
    endtask

    task automatic pattern_data();
        frame_d[0] = 8'h1E;
        frame_d[1] = 8'h2F;
        frame_d[2] = 8'hE0;
        for (int i = 3; i < 16; i++) frame_d[i] = 8'(i * 8'h11 + 3);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{n_send: 16, bad_pos: -1, cks_good: 1'b1, exp_n: 16, exp_done: 1'b1, exp_err: 1'b0};
        tbl[1] = '{n_send: 5,  bad_pos: -1, cks_good: 1'b1, exp_n: 5,  exp_done: 1'b0, exp_err: 1'b1};
        tbl[2] = '{n_send: 3,  bad_pos: 3,  cks_good: 1'b1, exp_n: 3,  exp_done: 1'b0, exp_err: 1'b1};
        tbl[3] = '{n_send: 16, bad_pos: -1, cks_good: 1'b0, exp_n: 16, exp_done: !CKS, exp_err: CKS};
        tbl[4] = '{n_send: 0,  bad_pos: -1, cks_good: 1'b1, exp_n: 0,  exp_done: 1'b0, exp_err: 1'b1};

        // Reset values while reset_i is held.
        repeat (4) @(negedge clk);
        check("rst ram_we", {31'd0, ram_we}, 0);
        check("rst ram_addr", {28'd0, ram_addr}, 0);
        check("rst ram_data", {24'd0, ram_data}, 0);
        check("rst cpu_reset", {31'd0, cpu_reset}, 1);
        check("rst load_done", {31'd0, load_done}, 0);
        check("rst err", {31'd0, err}, 0);
        reset_i = 1'b0;
        @(negedge clk);
        check("cpu_reset after reset release", {31'd0, cpu_reset}, 0);
        clear_obs();

        pattern_data();
        for (int t = 0; t < 5; t++) begin
            do_reset();
            send_frame(tbl[t].n_send, tbl[t].bad_pos, frame_sum() + (tbl[t].cks_good ? 8'd0 : 8'd1));
            expect_result($sformatf("tbl%0d", t), tbl[t].exp_n, tbl[t].exp_done, tbl[t].exp_err);
        end

        // Timeout boundary: still loading well inside the window, error after it.
        do_reset();
        send_frame(5, -1, 8'd0);
        repeat (300) @(negedge clk);
        check("timeout not yet", {31'd0, err}, 0);
        check("timeout not yet cpu_reset", {31'd0, cpu_reset}, 1);
        repeat (150) @(negedge clk);
        check("timeout err", {31'd0, err}, 1);
        check("timeout writes", wr_q.size(), 5);

        // Recovery from ERROR by a fresh valid frame.
        clear_obs();
        send_frame(16, -1, frame_sum());
        expect_result("recover", 16, 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // All-ones frame with wrong checksum, then a good frame.
        do_reset();
        for (int i = 0; i < 16; i++) frame_d[i] = 8'h01;
        check("ones sum", {24'd0, frame_sum()}, 32'h10);
        send_frame(16, -1, 8'h11);
        expect_result("bad cks", 16, 1'b0, 1'b1);
        clear_obs();
        send_frame(16, -1, 8'h10);
        expect_result("cks recover", 16, 1'b1, 1'b0);
        pattern_data();
`endif

        // Glitch and non-sync bytes in IDLE are ignored.
        do_reset();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h00, 1'b0);
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        check("idle writes", wr_q.size(), 0);
        check("idle cpu_reset", {31'd0, cpu_reset}, 0);
        check("idle err", {31'd0, err}, 0);
        frame_d[7] = 8'hA5;
        send_frame(16, -1, frame_sum());
        expect_result("a5 data", 16, 1'b1, 1'b0);
        pattern_data();

        // Reset in the middle of byte 9 abandons the load.
        do_reset();
        we_in_rst = 0;
        send_frame(8, -1, 8'd0);
        fork
            send_byte(frame_d[8], 1'b0);
            begin
                repeat (40) @(negedge clk);
                reset_i = 1'b1;
                repeat (60) @(negedge clk);
                reset_i = 1'b0;
            end
        join
        @(negedge clk);
        check("midreset writes", wr_q.size(), 8);
        check("writes during reset", we_in_rst, 0);
        check("midreset cpu_reset", {31'd0, cpu_reset}, 0);
        clear_obs();
        send_frame(16, -1, frame_sum());
        expect_result("after reset", 16, 1'b1, 1'b0);

        // Random frames against a frame-level model.
        for (int r = 0; r < 6; r++) begin
            int  mode;
            int  n;
            int  nsend;
            int  bpos;
            int  exp_n;
            bit  exp_done;
            mode = $urandom_range(0, 3);
            n    = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) frame_d[i] = 8'($urandom);
            nsend = (mode == 1 || mode == 2) ? n : 16;
            bpos  = (mode == 2) ? n : -1;
            exp_n = nsend;
            exp_done = (mode == 0) || (mode == 3 && !CKS);
            do_reset();
            send_frame(nsend, bpos, frame_sum() + ((mode == 3) ? 8'd1 : 8'd0));
            expect_result($sformatf("rand%0d m%0d", r, mode), exp_n, exp_done, !exp_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
